// File: rtl/mult_pkg.sv
// Shared types, constants and small helpers for the multiplier scheduler.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int N_REQ     = 2;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    // Product width for a given operand width.
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    // One-hot requester mask from a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mult_sched_if.sv
// Request/response bundle between the two requesters and the scheduler.
interface mult_sched_if
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [WIDTH-1:0]   req_a0;
    logic [WIDTH-1:0]   req_b0;
    logic [WIDTH-1:0]   req_a1;
    logic [WIDTH-1:0]   req_b1;
    logic [N_REQ-1:0]   rsp_valid;
    logic [N_REQ-1:0]   rsp_ready;
    logic [2*WIDTH-1:0] rsp_p;
    logic               busy;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_p, busy
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_p, busy
    );

endinterface

// File: rtl/mult_core.sv
// Shift-add multiplier datapath; the scheduler drives load and step.
// The multiplier is consumed MSB first, so the partial product doubles
// every step before the multiplicand is conditionally added.
module mult_core
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic                       step,
    input  logic [WIDTH-1:0]           a_in,
    input  logic [WIDTH-1:0]           b_in,
    output logic [prod_w(WIDTH)-1:0]   p
);

    localparam int PW = prod_w(WIDTH);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [PW-1:0]    p_r;
    logic [PW-1:0]    addend_s;

    // Multiplicand contribution for the current multiplier MSB.
    always_comb begin
        addend_s = {PW{1'b0}};
        if (b_r[WIDTH-1]) begin
            addend_s = {{WIDTH{1'b0}}, a_r};
        end else begin
            addend_s = {PW{1'b0}};
        end
    end

    // Operand capture on load, one shift-add per step, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= {WIDTH{1'b0}};
            b_r <= {WIDTH{1'b0}};
            p_r <= {PW{1'b0}};
        end else if (load) begin
            a_r <= a_in;
            b_r <= b_in;
            p_r <= {PW{1'b0}};
        end else if (step) begin
            p_r <= (p_r << 1'b1) + addend_s;
            b_r <= b_r << 1'b1;
        end else begin
            a_r <= a_r;
            b_r <= b_r;
            p_r <= p_r;
        end
    end

    assign p = p_r;

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one shift-add multiplier between two
// requesters. Accept in IDLE, WIDTH steps in RUN, hold the product in
// DONE until the owner takes it; a new accept can only happen from IDLE,
// which leaves a one-cycle gap after every response handshake.
module mult_sched
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    mult_sched_if.slave  bus
);

    localparam int PW = prod_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e            state_r;
    state_e            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              owner_r;
    logic              last_grant_r;
    logic [N_REQ-1:0]  rsp_valid_r;
    logic [N_REQ-1:0]  rsp_valid_s;
    logic              busy_r;

    logic              grant_s;
    logic [N_REQ-1:0]  ready_s;
    logic              accept_s;
    logic              load_s;
    logic              step_s;
    logic [WIDTH-1:0]  a_sel_s;
    logic [WIDTH-1:0]  b_sel_s;
    logic [PW-1:0]     p_s;

    // Round-robin grant and IDLE-only ready toward the granted requester.
    always_comb begin
        grant_s = 1'b0;
        case (bus.req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_grant_r;
            default: grant_s = 1'b0;
        endcase
        ready_s = 2'b00;
        if ((state_r == IDLE) && (bus.req_valid != 2'b00)) begin
            ready_s = onehot(grant_s);
        end else begin
            ready_s = 2'b00;
        end
        accept_s = |(bus.req_valid & ready_s);
    end

    // Operands of the granted requester feed the core load port.
    always_comb begin
        a_sel_s = bus.req_a0;
        b_sel_s = bus.req_b0;
        if (grant_s) begin
            a_sel_s = bus.req_a1;
            b_sel_s = bus.req_b1;
        end else begin
            a_sel_s = bus.req_a0;
            b_sel_s = bus.req_b0;
        end
    end

    // Next state, core controls and next response strobe.
    always_comb begin
        state_s     = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        rsp_valid_s = 2'b00;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST_STEP) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.rsp_ready[owner_r]) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (state_s == DONE) begin
            rsp_valid_s = onehot(owner_r);
        end else begin
            rsp_valid_s = 2'b00;
        end
    end

    // State, step counter, ownership and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            rsp_valid_r  <= 2'b00;
            busy_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            rsp_valid_r <= rsp_valid_s;
            busy_r      <= (state_s != IDLE);
            if (load_s) begin
                owner_r      <= grant_s;
                last_grant_r <= grant_s;
                cnt_r        <= {CNT_W{1'b0}};
            end else if (step_s) begin
                cnt_r <= cnt_r + 1'b1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    mult_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .step  (step_s),
        .a_in  (a_sel_s),
        .b_in  (b_sel_s),
        .p     (p_s)
    );

    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_p     = p_s;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched: vector table plus arbitration,
// backpressure and mid-run reset sequences.
module tb_mult_sched;
    import mult_pkg::*;

    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mult_sched_if #(.WIDTH(W)) bus ();

    mult_sched #(.WIDTH(W), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       r;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs [6];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ops(input logic r, input logic [3:0] a, input logic [3:0] b);
        if (r) begin
            bus.req_a1 = a;
            bus.req_b1 = b;
        end else begin
            bus.req_a0 = a;
            bus.req_b0 = b;
        end
    endtask

    // Waits (bounded) for any rsp_valid; lat counts edges after accept.
    task automatic wait_rsp(output int lat);
        lat = 99;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic consume(input string name, input logic r);
        bus.rsp_ready = onehot(r);
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        check({name, "_rsp_cleared"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    // Single request from one requester, latency and product checked.
    task automatic single(input string name, input logic r, input logic [3:0] a,
                          input logic [3:0] b, input logic [7:0] exp);
        int lat;
        set_ops(r, a, b);
        bus.req_valid = onehot(r);
        #1;
        check({name, "_ready"}, 32'(bus.req_ready), 32'(onehot(r)));
        @(negedge clk);
        bus.req_valid = 2'b00;
        check({name, "_busy"}, 32'(bus.busy), 32'd1);
        wait_rsp(lat);
        check({name, "_latency"}, 32'(lat), 32'd4);
        check({name, "_owner"}, 32'(bus.rsp_valid), 32'(onehot(r)));
        check({name, "_product"}, 32'(bus.rsp_p), 32'(exp));
        consume(name, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int j0;
        int j1;
        logic g;
        logic seen;
        logic [3:0] a0s [3];
        logic [3:0] b0s [3];
        logic [7:0] p0s [3];
        logic [3:0] a1s [3];
        logic [3:0] b1s [3];
        logic [7:0] p1s [3];

        vecs[0] = '{1'b0, 4'd9,  4'd12, 8'd108};
        vecs[1] = '{1'b1, 4'd15, 4'd15, 8'd225};
        vecs[2] = '{1'b0, 4'd0,  4'd13, 8'd0};
        vecs[3] = '{1'b1, 4'd15, 4'd1,  8'd15};
        vecs[4] = '{1'b0, 4'd1,  4'd1,  8'd1};
        vecs[5] = '{1'b1, 4'd10, 4'd7,  8'd70};

        a0s = '{4'd2, 4'd5, 4'd12};
        b0s = '{4'd3, 4'd5, 4'd11};
        p0s = '{8'd6, 8'd25, 8'd132};
        a1s = '{4'd4, 4'd13, 4'd14};
        b1s = '{4'd4, 4'd2, 4'd15};
        p1s = '{8'd16, 8'd26, 8'd210};

        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req_a0 = 4'd0;
        bus.req_b0 = 4'd0;
        bus.req_a1 = 4'd0;
        bus.req_b1 = 4'd0;

        // Reset state
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rsp_p", 32'(bus.rsp_p), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table; last entry leaves last_grant at requester 1
        for (int i = 0; i < 6; i++) begin
            single($sformatf("vec%0d", i), vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // Both valid: requester 0 first, requester 1 after the bubble
        set_ops(1'b0, 4'd3, 4'd5);
        set_ops(1'b1, 4'd7, 4'd6);
        bus.req_valid = 2'b11;
        #1;
        check("both_ready_first", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b10;
        #1;
        check("both_ready_run", 32'(bus.req_ready), 32'd0);
        wait_rsp(lat);
        check("both_lat0", 32'(lat), 32'd4);
        check("both_owner0", 32'(bus.rsp_valid), 32'd1);
        check("both_p0", 32'(bus.rsp_p), 32'd15);
        check("both_ready_done", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        check("both_rsp_cleared", 32'(bus.rsp_valid), 32'd0);
        check("both_ready_after_hs", 32'(bus.req_ready), 32'd2);
        @(negedge clk);
        bus.req_valid = 2'b00;
        wait_rsp(lat);
        check("both_lat1", 32'(lat), 32'd4);
        check("both_owner1", 32'(bus.rsp_valid), 32'd2);
        check("both_p1", 32'(bus.rsp_p), 32'd42);
        consume("both1", 1'b1);

        // Continuous contention: grants alternate 0,1,0,1,0,1
        j0 = 0;
        j1 = 0;
        set_ops(1'b0, a0s[0], b0s[0]);
        set_ops(1'b1, a1s[0], b1s[0]);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            g = (i % 2) == 1;
            #1;
            check($sformatf("rr%0d_ready", i), 32'(bus.req_ready), 32'(onehot(g)));
            @(negedge clk);
            if (!g) begin
                j0++;
                if (j0 < 3) set_ops(1'b0, a0s[j0], b0s[j0]);
                else        bus.req_valid[0] = 1'b0;
            end else begin
                j1++;
                if (j1 < 3) set_ops(1'b1, a1s[j1], b1s[j1]);
                else        bus.req_valid[1] = 1'b0;
            end
            wait_rsp(lat);
            check($sformatf("rr%0d_lat", i), 32'(lat), 32'd4);
            check($sformatf("rr%0d_owner", i), 32'(bus.rsp_valid), 32'(onehot(g)));
            check($sformatf("rr%0d_p", i), 32'(bus.rsp_p), g ? 32'(p1s[i/2]) : 32'(p0s[i/2]));
            bus.rsp_ready = 2'b11;
            @(negedge clk);
            bus.rsp_ready = 2'b00;
            check($sformatf("rr%0d_cleared", i), 32'(bus.rsp_valid), 32'd0);
        end

        // Backpressure in DONE with requester 1 pending
        set_ops(1'b0, 4'd6, 4'd7);
        set_ops(1'b1, 4'd8, 4'd9);
        bus.req_valid = 2'b11;
        #1;
        check("bp_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b10;
        wait_rsp(lat);
        check("bp_lat", 32'(lat), 32'd4);
        bus.rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("bp%0d_p", i), 32'(bus.rsp_p), 32'd42);
            check($sformatf("bp%0d_req_ready", i), 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        check("bp_cleared", 32'(bus.rsp_valid), 32'd0);
        check("bp_ready_next", 32'(bus.req_ready), 32'd2);
        @(negedge clk);
        bus.req_valid = 2'b00;
        check("bp_no_repeat", 32'(bus.rsp_valid), 32'd0);
        wait_rsp(lat);
        check("bp_lat1", 32'(lat), 32'd4);
        check("bp_owner1", 32'(bus.rsp_valid), 32'd2);
        check("bp_p1", 32'(bus.rsp_p), 32'd72);
        consume("bp1", 1'b1);

        // Reset during RUN step 2 aborts silently
        set_ops(1'b0, 4'd11, 4'd13);
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_rsp_p", 32'(bus.rsp_p), 32'd0);
        check("mrst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) seen = 1'b1;
        end
        check("mrst_no_stale_rsp", 32'(seen), 32'd0);
        single("post_rst", 1'b0, 4'd9, 4'd9, 8'd81);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
